// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hack_pkg
// Purpose  : Shared types, instruction field positions and decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package hack_pkg;

  localparam int TYPE_BIT = 15;
  localparam int A_BIT    = 12;
  localparam int COMP_LSB = 6;
  localparam int DEST_LSB = 3;
  localparam int JMP_LSB  = 0;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEMRD  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEMWR  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    KIND_A     = 2'd0,
    KIND_C_REG = 2'd1,
    KIND_C_MEM = 2'd2
  } kind_t;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } comp_t;

  typedef struct packed {
    logic a;
    logic d;
    logic m;
  } dest_t;

  // A C-instruction with the a-bit set needs M fetched before it can execute.
  function automatic kind_t instr_kind(input logic type_bit, input logic a_bit);
    if (!type_bit)
      return KIND_A;
    else if (a_bit)
      return KIND_C_MEM;
    else
      return KIND_C_REG;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hack_jump_unit.sv
`default_nettype none
// ============================================================================
// Module   : hack_jump_unit
// Purpose  : Resolves the jump condition from the j-bits and the ALU flags.
// Revision : 1.0 - initial release
// ============================================================================
module hack_jump_unit (
  input  logic [2:0] j,
  input  logic       zr,
  input  logic       ng,
  output logic       jmp
);

  assign jmp = (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);

endmodule
`default_nettype wire

// File: rtl/hack_cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hack_cpu_ctrl
// Purpose  : Multicycle Hack CPU control/register stage with req/ack buses.
// Revision : 1.0 - initial release
// ============================================================================
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter int                ADDR_W   = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ack,
  input  logic [15:0]       instr_data,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       alu_x,
  output logic [15:0]       alu_y,
  output logic              alu_zx,
  output logic              alu_nx,
  output logic              alu_zy,
  output logic              alu_ny,
  output logic              alu_f,
  output logic              alu_no,
  input  logic [15:0]       alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [ADDR_W-1:0] pc,
  output logic              retire
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_run;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_a;
  logic [15:0]       r_d;
  logic [15:0]       r_ir;
  logic [15:0]       r_m;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_wdata;

  kind_t             w_kind;
  comp_t             w_comp;
  dest_t             w_dest;
  logic              w_jmp;
  logic              w_instr_done;
  logic              w_mem_done;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_kind   = instr_kind(r_ir[TYPE_BIT], r_ir[A_BIT]);
  assign w_comp   = comp_t'(r_ir[COMP_LSB +: 6]);
  assign w_dest   = dest_t'(r_ir[DEST_LSB +: 3]);
  assign w_pc_inc = r_pc + ADDR_W'(1);

  hack_jump_unit u_jump (
    .j   (r_ir[JMP_LSB +: 3]),
    .zr  (alu_zr),
    .ng  (alu_ng),
    .jmp (w_jmp)
  );

  assign w_instr_done = instr_req & instr_ack;
  assign w_mem_done   = mem_ack & (mem_rd_req | mem_wr_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_FETCH;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH:  if (w_instr_done) w_state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (w_kind)
          KIND_A:     w_state_nxt = ST_FETCH;
          KIND_C_MEM: w_state_nxt = ST_MEMRD;
          default:    w_state_nxt = ST_EXEC;
        endcase
      end
      ST_MEMRD:  if (w_mem_done) w_state_nxt = ST_EXEC;
      ST_EXEC:   w_state_nxt = w_dest.m ? ST_MEMWR : ST_FETCH;
      ST_MEMWR:  if (w_mem_done) w_state_nxt = ST_FETCH;
      default:   w_state_nxt = ST_FETCH;
    endcase
  end

  // r_run keeps instr_req low while reset is held and for the first cycle after.
  always_comb begin
    instr_req  = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    retire     = 1'b0;
    case (r_state)
      ST_FETCH:  instr_req  = r_run;
      ST_DECODE: retire     = (w_kind == KIND_A);
      ST_MEMRD:  mem_rd_req = 1'b1;
      ST_EXEC:   retire     = ~w_dest.m;
      ST_MEMWR: begin
        mem_wr_req = 1'b1;
        retire     = mem_ack;
      end
      default: ;
    endcase
  end

  // Jump target and store address both read r_a before this cycle's writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run       <= 1'b0;
      r_pc        <= RESET_PC;
      r_a         <= '0;
      r_d         <= '0;
      r_ir        <= '0;
      r_m         <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        ST_FETCH: begin
          if (w_instr_done) r_ir <= instr_data;
        end
        ST_DECODE: begin
          if (w_kind == KIND_A) begin
            r_a  <= {1'b0, r_ir[14:0]};
            r_pc <= w_pc_inc;
          end else begin
            r_mem_addr <= r_a[ADDR_W-1:0];
          end
        end
        ST_MEMRD: begin
          if (w_mem_done) r_m <= mem_rdata;
        end
        ST_EXEC: begin
          if (w_dest.a) r_a <= alu_out;
          if (w_dest.d) r_d <= alu_out;
          if (w_dest.m) begin
            r_mem_addr  <= r_a[ADDR_W-1:0];
            r_mem_wdata <= alu_out;
          end
          r_pc <= w_jmp ? r_a[ADDR_W-1:0] : w_pc_inc;
        end
        default: ;
      endcase
    end
  end

  assign instr_addr = r_pc;
  assign pc         = r_pc;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

  assign alu_x  = r_d;
  assign alu_y  = r_ir[A_BIT] ? r_m : r_a;
  assign alu_zx = w_comp.zx;
  assign alu_nx = w_comp.nx;
  assign alu_zy = w_comp.zy;
  assign alu_ny = w_comp.ny;
  assign alu_f  = w_comp.f;
  assign alu_no = w_comp.no;

endmodule
`default_nettype wire

// File: tb/tb_hack_cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hack_cpu_ctrl
// Purpose  : Directed self-checking bench for hack_cpu_ctrl with ROM/RAM/ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hack_cpu_ctrl;

  localparam int ADDR_W = 15;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              instr_req;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_ack;
  logic [15:0]       instr_data;
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_ack;
  logic [15:0]       alu_x;
  logic [15:0]       alu_y;
  logic              alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0]       alu_out;
  logic              alu_zr, alu_ng;
  logic [ADDR_W-1:0] pc;
  logic              retire;

  always #5 clk = ~clk;

  hack_cpu_ctrl #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack), .instr_data(instr_data),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .pc(pc), .retire(retire)
  );

  // Memories and external Hack ALU
  logic [15:0] rom [0:63];
  logic [15:0] ram [0:63];
  int          mem_delay = 0;
  int          mem_wait  = 0;
  logic        ack_force = 1'b0;
  logic [ADDR_W-1:0] wr_log_addr = '0;
  logic [15:0]       wr_log_data = '0;

  function automatic logic [17:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic zx, input logic nx, input logic zy,
                                           input logic ny, input logic f, input logic no);
    logic [15:0] a, b, o;
    a = zx ? 16'h0 : x;
    a = nx ? ~a : a;
    b = zy ? 16'h0 : y;
    b = ny ? ~b : b;
    o = f ? (a + b) : (a & b);
    o = no ? ~o : o;
    return {(o == 16'h0), o[15], o};
  endfunction

  assign {alu_zr, alu_ng, alu_out} = hack_alu(alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no);
  assign instr_ack  = instr_req;
  assign instr_data = rom[instr_addr[5:0]];
  assign mem_rdata  = ram[mem_addr[5:0]];
  assign mem_ack    = ((mem_rd_req | mem_wr_req) && (mem_wait >= mem_delay)) || ack_force;

  always @(posedge clk) begin
    if ((mem_rd_req | mem_wr_req) && !mem_ack) mem_wait <= mem_wait + 1;
    else                                       mem_wait <= 0;
    if (mem_wr_req && mem_ack) begin
      wr_log_addr <= mem_addr;
      wr_log_data <= mem_wdata;
    end
  end

  // Passive monitor
  int          cyc = 0, ret_cnt = 0, ret_last = 0, ret_prev = 0, rd_cnt = 0, wr_cnt = 0;
  logic [ADDR_W-1:0] rd_addr_seen = '0;
  logic [15:0] cap_alu_x = '0, cap_alu_y = '0;
  logic        rd_done_prev = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (retire) begin
      ret_cnt  = ret_cnt + 1;
      ret_prev = ret_last;
      ret_last = cyc;
    end
    if (mem_rd_req) begin
      rd_cnt       = rd_cnt + 1;
      rd_addr_seen = mem_addr;
    end
    if (mem_wr_req) wr_cnt = wr_cnt + 1;
    if (rd_done_prev) begin
      cap_alu_x = alu_x;
      cap_alu_y = alu_y;
    end
    rd_done_prev = mem_rd_req && mem_ack;
  end

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_retires(input int n, input int budget, output bit ok);
    int target;
    target = ret_cnt + n;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (ret_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    step();
    step();
    checks++; if (pc !== 15'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 15'h0); end
    checks++; if ({instr_req, mem_rd_req, mem_wr_req, retire} !== 4'b0000) begin errors++;
      $display("FAIL reset_outputs: got %b expected %b", {instr_req, mem_rd_req, mem_wr_req, retire}, 4'b0000); end
    checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata: got %h expected %h", mem_wdata, 16'h0); end
    checks++; if ({dut.r_a, dut.r_d} !== 32'h0) begin errors++; $display("FAIL reset_ad: got %h expected %h", {dut.r_a, dut.r_d}, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int b_ret, b_rd, b_wr;
    bit ok;
    b_ret = ret_cnt; b_rd = rd_cnt; b_wr = wr_cnt;
    wait_retires(2, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got %0d retires expected %0d", ret_cnt - b_ret, 2); end
    checks++; if (ret_last - ret_prev !== 3) begin errors++; $display("FAIL basic_c_latency: got %0d expected %0d", ret_last - ret_prev, 3); end
    step();
    checks++; if (dut.r_a !== 16'h0005) begin errors++; $display("FAIL basic_a: got %h expected %h", dut.r_a, 16'h0005); end
    checks++; if (dut.r_d !== 16'h0005) begin errors++; $display("FAIL basic_d: got %h expected %h", dut.r_d, 16'h0005); end
    checks++; if (pc !== 15'd2) begin errors++; $display("FAIL basic_pc: got %h expected %h", pc, 15'd2); end
    checks++; if (ret_cnt - b_ret !== 2) begin errors++; $display("FAIL basic_retires: got %0d expected %0d", ret_cnt - b_ret, 2); end
    checks++; if ((rd_cnt - b_rd) + (wr_cnt - b_wr) !== 0) begin errors++;
      $display("FAIL basic_no_mem: got %0d expected %0d", (rd_cnt - b_rd) + (wr_cnt - b_wr), 0); end
  endtask

  task automatic test_mem_read();
    int b_rd;
    bit ok;
    b_rd = rd_cnt;
    wait_retires(2, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_timeout: got %b expected %b", ok, 1'b1); end
    checks++; if (ret_last - ret_prev !== 4) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", ret_last - ret_prev, 4); end
    step();
    checks++; if (rd_cnt - b_rd !== 1) begin errors++; $display("FAIL rd_req_cycles: got %0d expected %0d", rd_cnt - b_rd, 1); end
    checks++; if (rd_addr_seen !== 15'd7) begin errors++; $display("FAIL rd_addr: got %h expected %h", rd_addr_seen, 15'd7); end
    checks++; if (cap_alu_y !== 16'd3) begin errors++; $display("FAIL rd_alu_y: got %h expected %h", cap_alu_y, 16'd3); end
    checks++; if (cap_alu_x !== 16'd5) begin errors++; $display("FAIL rd_alu_x: got %h expected %h", cap_alu_x, 16'd5); end
    checks++; if (dut.r_d !== 16'd8) begin errors++; $display("FAIL rd_d: got %h expected %h", dut.r_d, 16'd8); end
    checks++; if (pc !== 15'd4) begin errors++; $display("FAIL rd_pc: got %h expected %h", pc, 15'd4); end
  endtask

  task automatic test_mem_write();
    bit found;
    int b_ret;
    b_ret = ret_cnt;
    mem_delay = 3;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_wr_req) begin found = 1'b1; break; end
      step();
    end
    checks++; if (!found) begin errors++; $display("FAIL wr_req_timeout: got %b expected %b", found, 1'b1); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({mem_wr_req, mem_rd_req, mem_addr, mem_wdata} !== {1'b1, 1'b0, 15'd9, 16'd8}) begin errors++;
        $display("FAIL wr_stable_%0d: got req=%b rd=%b addr=%h data=%h expected req=1 rd=0 addr=0009 data=0008",
                 k, mem_wr_req, mem_rd_req, mem_addr, mem_wdata); end
      step();
    end
    mem_delay = 0;
    checks++; if (mem_wr_req !== 1'b0) begin errors++; $display("FAIL wr_req_drop: got %b expected %b", mem_wr_req, 1'b0); end
    checks++; if ({wr_log_addr, wr_log_data} !== {15'd9, 16'd8}) begin errors++;
      $display("FAIL wr_commit: got %h/%h expected %h/%h", wr_log_addr, wr_log_data, 15'd9, 16'd8); end
    checks++; if (pc !== 15'd6) begin errors++; $display("FAIL wr_pc: got %h expected %h", pc, 15'd6); end
    checks++; if (ret_cnt - b_ret !== 2) begin errors++; $display("FAIL wr_retires: got %0d expected %0d", ret_cnt - b_ret, 2); end
  endtask

  task automatic test_jump();
    bit ok;
    wait_retires(3, 30, ok);
    step();
    checks++; if (!ok || pc !== 15'h10) begin errors++; $display("FAIL jgt_taken: got %h expected %h", pc, 15'h10); end
    wait_retires(2, 30, ok);
    step();
    checks++; if (!ok || pc !== 15'h12) begin errors++; $display("FAIL jgt_zero: got %h expected %h", pc, 15'h12); end
    checks++; if (dut.r_d !== 16'h0) begin errors++; $display("FAIL jgt_zero_d: got %h expected %h", dut.r_d, 16'h0); end
    wait_retires(2, 30, ok);
    step();
    checks++; if (!ok || pc !== 15'h14) begin errors++; $display("FAIL jgt_neg: got %h expected %h", pc, 15'h14); end
    checks++; if (dut.r_d !== 16'hFFFF) begin errors++; $display("FAIL jgt_neg_d: got %h expected %h", dut.r_d, 16'hFFFF); end
  endtask

  task automatic test_am_inc();
    bit ok;
    wait_retires(2, 40, ok);
    step();
    checks++; if (!ok) begin errors++; $display("FAIL am_timeout: got %b expected %b", ok, 1'b1); end
    checks++; if (rd_addr_seen !== 15'h20) begin errors++; $display("FAIL am_rd_addr: got %h expected %h", rd_addr_seen, 15'h20); end
    checks++; if ({wr_log_addr, wr_log_data} !== {15'h20, 16'h8000}) begin errors++;
      $display("FAIL am_write: got %h/%h expected %h/%h", wr_log_addr, wr_log_data, 15'h20, 16'h8000); end
    checks++; if (dut.r_a !== 16'h8000) begin errors++; $display("FAIL am_a: got %h expected %h", dut.r_a, 16'h8000); end
    checks++; if (pc !== 15'd22) begin errors++; $display("FAIL am_pc: got %h expected %h", pc, 15'd22); end
  endtask

  task automatic test_reset_midflight();
    bit found;
    bit ok;
    int b_rd;
    mem_delay = 100;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd_req) begin found = 1'b1; break; end
      step();
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_rd_timeout: got %b expected %b", found, 1'b1); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({instr_req, mem_rd_req, mem_wr_req} !== 3'b000) begin errors++;
      $display("FAIL mid_req_drop: got %b expected %b", {instr_req, mem_rd_req, mem_wr_req}, 3'b000); end
    checks++; if (pc !== 15'h0) begin errors++; $display("FAIL mid_pc: got %h expected %h", pc, 15'h0); end
    @(negedge clk);
    rst_n     = 1'b1;
    mem_delay = 0;
    ack_force = 1'b1;
    b_rd      = rd_cnt;
    @(negedge clk);
    ack_force = 1'b0;
    #1;
    checks++; if ({instr_req, instr_addr, mem_rd_req} !== {1'b1, 15'h0, 1'b0}) begin errors++;
      $display("FAIL mid_refetch: got req=%b addr=%h rd=%b expected req=1 addr=0000 rd=0", instr_req, instr_addr, mem_rd_req); end
    wait_retires(1, 20, ok);
    step();
    checks++; if (!ok || pc !== 15'd1) begin errors++; $display("FAIL mid_restart_pc: got %h expected %h", pc, 15'd1); end
    checks++; if (dut.r_a !== 16'h0005) begin errors++; $display("FAIL mid_restart_a: got %h expected %h", dut.r_a, 16'h0005); end
    checks++; if (rd_cnt - b_rd !== 0) begin errors++; $display("FAIL mid_late_ack: got %0d expected %0d", rd_cnt - b_rd, 0); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom[i] = 16'h0000;
      ram[i] = 16'h0000;
    end
    rom[0]  = 16'h0005; rom[1]  = 16'hEC10;
    rom[2]  = 16'h0007; rom[3]  = 16'hF090;
    rom[4]  = 16'h0009; rom[5]  = 16'hE308;
    rom[6]  = 16'h0010; rom[7]  = 16'hEFD0; rom[8]  = 16'hE301;
    rom[16] = 16'hEA90; rom[17] = 16'hE301;
    rom[18] = 16'hEE90; rom[19] = 16'hE301;
    rom[20] = 16'h0020; rom[21] = 16'hFDE8;
    rom[22] = 16'h0030; rom[23] = 16'hFC10;
    ram[7]    = 16'h0003;
    ram[6'h20] = 16'h7FFF;

    test_reset();
    test_basic();
    test_mem_read();
    test_mem_write();
    test_jump();
    test_am_inc();
    test_reset_midflight();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
